// File: rtl/dmem_map_pkg.sv
// dmem_map_pkg: MMIO address map, done-trigger default and UART serializer states
// shared by the data-memory block and its sub-modules.
package dmem_map_pkg;
    localparam logic [31:0] ADDR_DONE      = 32'h0000_2000;
    localparam logic [31:0] ADDR_UART_DATA = 32'h0000_2004;
    localparam logic [31:0] ADDR_UART_STAT = 32'h0000_2008;
    localparam logic [31:0] ADDR_CYCLE_CNT = 32'h0000_200C;
    localparam logic [31:0] DONE_VALUE_DEF = 32'hCAFE_BABE;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: DEPTH x 8 byte FIFO; a push while full only lands if a pop frees a slot that cycle.
module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_q];

    always_ff @(posedge clk)
        if (do_push) mem_q[wr_q] <= data_i;

    // Power-of-2 depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_q + AW'(do_push);
            rd_q    <= rd_q + AW'(do_pop);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/dmem_mmio.sv
// dmem_mmio: core data RAM plus DONE flag and UART TX MMIO; read data is combinational on addr.
// Define DMEM_MMIO_CYCLE_CNT_EN to add a run-length cycle counter at 0x200C.
module dmem_mmio
    import dmem_map_pkg::*;
#(
    parameter int          RAM_WORDS    = 1024,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          CLKS_PER_BIT = 16,
    parameter logic [31:0] DONE_VALUE   = DONE_VALUE_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dmem_we,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        done,
    output logic        uart_tx,
    output logic        fifo_overflow
);
    localparam int RAW = $clog2(RAM_WORDS);
    localparam int CW  = $clog2(CLKS_PER_BIT);

    logic [31:0]    ram [RAM_WORDS];
    logic           ram_hit, push, pop, bit_end;
    logic [RAW-1:0] ram_idx;
    logic           done_q, done_d, ovf_q, ovf_d;
    logic           fifo_full, fifo_empty;
    logic [7:0]     fifo_data, shift_q;
    uart_state_e    state_q;
    logic [2:0]     bit_q;
    logic [CW-1:0]  cnt_q;
    logic           tx_q;

    assign ram_hit       = dmem_addr < 32'(RAM_WORDS * 4);
    assign ram_idx       = dmem_addr[RAW+1:2];
    assign push          = dmem_we && dmem_addr == ADDR_UART_DATA;
    assign pop           = state_q == IDLE && !fifo_empty;
    assign bit_end       = cnt_q == CW'(CLKS_PER_BIT - 1);
    assign done_d        = done_q || (dmem_we && dmem_addr == ADDR_DONE && dmem_wdata == DONE_VALUE);
    assign ovf_d         = ovf_q || (push && fifo_full && !pop);
    assign done          = done_q;
    assign fifo_overflow = ovf_q;
    assign uart_tx       = tx_q;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (push),
        .pop_i  (pop),
        .data_i (dmem_wdata[7:0]),
        .data_o (fifo_data),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    always_ff @(posedge clk)
        if (dmem_we && ram_hit) ram[ram_idx] <= dmem_wdata;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            done_q <= done_d;
            ovf_q  <= ovf_d;
        end

    // The shift register moves right so the next bit to send is always at [1] on a bit boundary.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: if (pop) begin
                    state_q <= START;
                    shift_q <= fifo_data;
                    cnt_q   <= '0;
                    tx_q    <= 1'b0;
                end
                START: if (bit_end) begin
                    state_q <= DATA;
                    cnt_q   <= '0;
                    tx_q    <= shift_q[0];
                end else cnt_q <= cnt_q + 1'b1;
                DATA: if (!bit_end) cnt_q <= cnt_q + 1'b1;
                else if (bit_q == 3'd7) begin
                    state_q <= STOP;
                    cnt_q   <= '0;
                    bit_q   <= '0;
                    tx_q    <= 1'b1;
                end else begin
                    cnt_q   <= '0;
                    bit_q   <= bit_q + 1'b1;
                    shift_q <= {1'b0, shift_q[7:1]};
                    tx_q    <= shift_q[1];
                end
                STOP: if (bit_end) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else cnt_q <= cnt_q + 1'b1;
                default: state_q <= IDLE;
            endcase
        end

`ifdef DMEM_MMIO_CYCLE_CNT_EN
    logic [31:0] cyc_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cyc_q <= '0;
        else if (!done_q) cyc_q <= cyc_q + 1'b1;
`endif

    always_comb begin
        dmem_rdata = '0;
        if (ram_hit) dmem_rdata = ram[ram_idx];
        else if (dmem_addr == ADDR_DONE) dmem_rdata = {31'b0, done_q};
        else if (dmem_addr == ADDR_UART_STAT) dmem_rdata = {28'b0, ovf_q, fifo_empty, fifo_full, state_q != IDLE};
`ifdef DMEM_MMIO_CYCLE_CNT_EN
        else if (dmem_addr == ADDR_CYCLE_CNT) dmem_rdata = cyc_q;
`endif
    end
endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: scoreboard bench for dmem_mmio; reads and UART frames are checked by
// monitors against a cycle-level reference model of the memory map and serializer timing.
module tb_dmem_mmio;
    localparam int C = 4;

    typedef struct { logic [31:0] addr; logic [31:0] rdata; logic done; logic ovf; } rd_exp_t;
    typedef struct { logic [7:0] b; int st; } tx_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        done, uart_tx, fifo_overflow;

    int checks = 0, fails = 0;
    bit rd_chk = 0;
    rd_exp_t rq[$];
    tx_exp_t tq[$];
    logic [7:0] fq[$];
    logic [31:0] mram [1024];
    bit mdone = 0, movf = 0;
    int cyc = 0, next_free = 0;
`ifdef DMEM_MMIO_CYCLE_CNT_EN
    logic [31:0] mcnt = '0;
`endif

    always #5 clk = ~clk;

    dmem_mmio #(.RAM_WORDS(1024), .FIFO_DEPTH(8), .CLKS_PER_BIT(C), .DONE_VALUE(32'hCAFEBABE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .done         (done),
        .uart_tx      (uart_tx),
        .fifo_overflow(fifo_overflow)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [31:0] a);
        if (a < 32'h1000) return mram[a[11:2]];
        if (a == 32'h2000) return {31'b0, mdone};
        if (a == 32'h2008) return {28'b0, movf, fq.size() == 0, fq.size() == 8, cyc <= next_free - 2};
`ifdef DMEM_MMIO_CYCLE_CNT_EN
        if (a == 32'h200C) return mcnt;
`endif
        return 32'h0;
    endfunction

    // Reference model: a frame occupies 10*C cycles after its pop edge, and the next pop
    // can happen no earlier than one idle cycle later.
    always @(posedge clk) if (rst_n) begin
        int sz;
        bit pp;
        tx_exp_t e;
        cyc++;
`ifdef DMEM_MMIO_CYCLE_CNT_EN
        if (!mdone) mcnt++;
`endif
        sz = fq.size();
        pp = cyc >= next_free && sz > 0;
        if (pp) begin
            e.b = fq.pop_front();
            e.st = cyc;
            tq.push_back(e);
            next_free = cyc + 10 * C + 1;
        end
        if (dmem_we) begin
            if (dmem_addr == 32'h2004) begin
                if (sz < 8 || pp) fq.push_back(dmem_wdata[7:0]);
                else movf = 1;
            end
            if (dmem_addr < 32'h1000) mram[dmem_addr[11:2]] = dmem_wdata;
            if (dmem_addr == 32'h2000 && dmem_wdata == 32'hCAFEBABE) mdone = 1;
        end
    end

    always @(negedge clk) if (rd_chk) begin
        rd_exp_t e;
        if (rq.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL rd_queue: no expectation queued");
        end else begin
            e = rq.pop_front();
            chk($sformatf("rdata@%h", e.addr), dmem_rdata, e.rdata);
            chk("done", {31'b0, done}, {31'b0, e.done});
            chk("fifo_overflow", {31'b0, fifo_overflow}, {31'b0, e.ovf});
        end
    end

    initial begin : uart_mon
        logic prev;
        logic [10*C-1:0] s;
        logic [7:0] b;
        bit ab;
        int st;
        tx_exp_t e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) prev = 1'b1;
            else if (prev && !uart_tx) begin
                st = cyc;
                ab = 0;
                s = '0;
                for (int j = 1; j < 10 * C && !ab; j++) begin
                    @(negedge clk);
                    if (!rst_n) ab = 1;
                    else s[j] = uart_tx;
                end
                prev = 1'b1;
                if (!ab) begin
                    for (int i = 0; i < 8; i++) b[i] = s[C * (1 + i) + C / 2];
                    if (tq.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL uart_frame: unexpected byte %h got, none expected", b);
                    end else begin
                        e = tq.pop_front();
                        chk("uart_byte", {24'b0, b}, {24'b0, e.b});
                        chk("uart_start_cycle", st, e.st);
                        chk("uart_stop_bit", {31'b0, s[9 * C + C / 2]}, 32'd1);
                    end
                end
            end else prev = uart_tx;
        end
    end

    task automatic op(input bit w, input logic [31:0] a, input logic [31:0] d);
        rd_exp_t e;
        @(posedge clk);
        #1;
        dmem_we = w;
        dmem_addr = a;
        dmem_wdata = d;
        e.addr = a;
        e.rdata = mread(a);
        e.done = mdone;
        e.ovf = movf;
        rq.push_back(e);
        rd_chk = 1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        dmem_we = 0;
        rd_chk = 0;
        #1 rst_n = 0;
        #1 chk("uart_tx_async_reset", {31'b0, uart_tx}, 32'd1);
        fq.delete();
        tq.delete();
        mdone = 0;
        movf = 0;
        next_free = 0;
`ifdef DMEM_MMIO_CYCLE_CNT_EN
        mcnt = '0;
`endif
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
    endtask

    task automatic drain();
        int n = 0;
        while ((fq.size() > 0 || tq.size() > 0 || cyc <= next_free - 2) && n < 3000) begin
            op(0, 32'h2008, 0);
            n++;
        end
        chk("drain_within_budget", {31'b0, n < 3000}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, d;
        bit w;
        foreach (mram[i]) mram[i] = '0;
        rst_n = 0;
        dmem_we = 0;
        dmem_addr = 0;
        dmem_wdata = 0;
        #12;
        chk("uart_tx_reset", {31'b0, uart_tx}, 32'd1);
        chk("done_reset", {31'b0, done}, 32'd0);
        chk("ovf_reset", {31'b0, fifo_overflow}, 32'd0);
        #20 rst_n = 1;

        op(0, 32'h2000, 0); op(0, 32'h2008, 0);
        op(1, 32'h40, 32'h12345678); op(0, 32'h40, 0); op(0, 32'h44, 0); op(0, 32'h3000, 0);
        op(1, 32'h80, 32'hAAAA5555); op(0, 32'h82, 0);
        op(1, 32'hFFC, 32'h0BADF00D); op(1, 32'h1000, 32'h11111111); op(0, 32'hFFC, 0);
        op(0, 32'h1000, 0); op(0, 32'h0, 0); op(0, 32'h2004, 0); op(0, 32'h200C, 0);

        op(1, 32'h2000, 32'hDEADBEEF); op(0, 32'h2000, 0);
        op(1, 32'h2000, 32'hCAFEBABE); op(0, 32'h2000, 0);
        op(1, 32'h2000, 32'h0); op(0, 32'h2000, 0); op(0, 32'h200C, 0); op(0, 32'h200C, 0);
        do_reset();
        op(0, 32'h2000, 0);

        op(1, 32'h2004, 32'h41); op(0, 32'h2008, 0);
        repeat (4 * C) op(0, 32'h2008, 0);
        drain();

        op(1, 32'h2004, 32'h41); op(1, 32'h2004, 32'h5A); op(1, 32'h2004, 32'hC3); op(1, 32'h2004, 32'h7E);
        repeat (4 * C - 1) op(0, 32'h2008, 0);
        do_reset();
        op(0, 32'h2008, 0); op(0, 32'h2000, 0);
        repeat (12 * C) op(0, 32'h2008, 0);

        op(1, 32'h2004, 32'hA5); op(0, 32'h2008, 0);
        for (int i = 0; i < 9; i++) op(1, 32'h2004, 32'h30 + i);
        op(0, 32'h2008, 0); op(0, 32'h2008, 0);
        drain();
        op(0, 32'h2008, 0);
        do_reset();

        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 7))
                0, 1, 2: a = 32'h40 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
                3: a = 32'h2000;
                4: a = 32'h2004;
                5: a = 32'h2008;
                6: a = 32'h200C;
                default: case ($urandom_range(0, 3))
                    0: a = 32'hFFC;
                    1: a = 32'h1000;
                    2: a = 32'h3000;
                    default: a = $urandom;
                endcase
            endcase
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            if (a == 32'h2000 && $urandom_range(0, 7) == 0) d = 32'hCAFEBABE;
            op(w, a, d);
        end
        drain();
        repeat (2) op(0, 32'h2008, 0);
        @(posedge clk);
        #1 rd_chk = 0;
        chk("tx_queue_empty", tq.size(), 32'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
